// File: rtl/pixel_priority_sequencer_pkg.sv
// pe_pkg: shared types and constants for the per-pixel layer priority sequencer.
`default_nettype none

package pe_pkg;

  typedef struct packed {
    logic [1:0]  prio;
    logic [2:0]  layer_id;
    logic [14:0] color;
  } pe_word_t;

  localparam logic [2:0] LAYER_OBJ      = 3'd4;
  localparam logic [2:0] LAYER_BACKDROP = 3'd5;
  localparam logic [1:0] BACKDROP_PRIO  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } pe_state_t;

  // OBJ first so it wins priority ties against every background.
  localparam logic [2:0] SCAN_ORDER [5] = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd3};

  function automatic pe_word_t backdrop_word(input logic [14:0] color);
    backdrop_word = '{prio: BACKDROP_PRIO, layer_id: LAYER_BACKDROP, color: color};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_priority_sequencer_beats.sv
// pe_candidate_beats: decides whether a candidate displaces an incumbent word.
`default_nettype none

module pe_candidate_beats
  import pe_pkg::*;
#(
  parameter int PRIO_W = 2
) (
  input  pe_word_t cand,
  input  logic     cand_eligible,
  input  pe_word_t inc,
  input  logic     inc_is_backdrop,
  output logic     beats
);

  logic [PRIO_W-1:0] cand_prio;
  logic [PRIO_W-1:0] inc_prio;

  assign cand_prio = cand.prio;
  assign inc_prio  = inc.prio;

  // Strict less-than: equal priority keeps the earlier-scanned incumbent.
  assign beats = cand_eligible && (inc_is_backdrop || (cand_prio < inc_prio));

endmodule

`default_nettype wire

// File: rtl/pixel_priority_sequencer.sv
// pixel_priority_sequencer: scans five layer candidates one per cycle and
// emits the top and runner-up words, falling back to the backdrop colour.
`default_nettype none

module pixel_priority_sequencer
  import pe_pkg::*;
#(
  parameter int NUM_LAYERS = 5,
  parameter int PRIO_W     = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_LAYERS*20-1:0] layer_words,
  input  logic [NUM_LAYERS-1:0]    layer_opaque,
  input  logic [NUM_LAYERS-1:0]    mask,
  input  logic [14:0]              backdrop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [19:0]              top_word,
  output logic [19:0]              second_word
);

  pe_state_t                 state;
  logic [2:0]                idx;
  logic [NUM_LAYERS*20-1:0]  words_r;
  logic [NUM_LAYERS-1:0]     elig_r;
  pe_word_t                  top_r;
  pe_word_t                  second_r;
  logic                      top_is_bd;
  logic                      second_is_bd;

  logic [2:0]  slot;
  pe_word_t    cand;
  logic        cand_elig;
  logic        beats_top;
  logic        beats_second;

  assign slot      = SCAN_ORDER[idx];
  assign cand      = pe_word_t'(words_r[int'(slot)*20 +: 20]);
  assign cand_elig = elig_r[slot];

  pe_candidate_beats #(.PRIO_W(PRIO_W)) u_vs_top (
    .cand            (cand),
    .cand_eligible   (cand_elig),
    .inc             (top_r),
    .inc_is_backdrop (top_is_bd),
    .beats           (beats_top)
  );

  pe_candidate_beats #(.PRIO_W(PRIO_W)) u_vs_second (
    .cand            (cand),
    .cand_eligible   (cand_elig),
    .inc             (second_r),
    .inc_is_backdrop (second_is_bd),
    .beats           (beats_second)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= 3'd0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      words_r      <= '0;
      elig_r       <= '0;
      top_r        <= '0;
      second_r     <= '0;
      top_is_bd    <= 1'b0;
      second_is_bd <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            words_r      <= layer_words;
            elig_r       <= layer_opaque & mask;
            top_r        <= backdrop_word(backdrop);
            second_r     <= backdrop_word(backdrop);
            top_is_bd    <= 1'b1;
            second_is_bd <= 1'b1;
            idx          <= 3'd0;
            in_ready     <= 1'b0;
            state        <= SCAN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SCAN: begin
          if (beats_top) begin
            second_r     <= top_r;
            second_is_bd <= top_is_bd;
            top_r        <= cand;
            top_is_bd    <= 1'b0;
          end else if (beats_second) begin
            second_r     <= cand;
            second_is_bd <= 1'b0;
          end
          if (idx == 3'(NUM_LAYERS - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign top_word    = top_r;
  assign second_word = second_r;

endmodule

`default_nettype wire

// File: doc/pixel_priority_sequencer.md
Name: pixel_priority_sequencer

Overview:
Sequential per-pixel layer resolver in the graphics priority-evaluation stage. It accepts one pixel's five layer candidate words (BG0–BG3, OBJ) plus enable and opacity masks. It scans the candidates one per cycle and emits the winning (top) word and the runner-up (second) word for the colour-effects/blend stage. Unused slots fall back to the backdrop colour.

Parameters:
NUM_LAYERS, 5, number of candidate slots (slot 4 = OBJ, slots 0–3 = BG0–BG3); fixed scan order is OBJ, BG0, BG1, BG2, BG3.
PRIO_W, 2, width of the priority field.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  candidate set presented
in_ready  output  1  block can accept a candidate set
layer_words  input  NUM_LAYERS*20  packed words, slot n at [20n+19:20n]; word = {prio[19:18], layer_id[17:15], bgr555[14:0]}
layer_opaque  input  NUM_LAYERS  1 = slot pixel non-transparent
mask  input  NUM_LAYERS  1 = layer enabled (DISPCNT AND window)
backdrop  input  15  backdrop BGR555 colour, sampled with the candidate set
out_valid  output  1  top/second results valid
out_ready  input  1  downstream accepts results
top_word  output  20  winning word
second_word  output  20  runner-up word

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted: state=IDLE, in_ready=0, out_valid=0, top_word=0, second_word=0, scan index=0. An in-flight pixel is discarded and no partial result is emitted.
- FSM states:
  - IDLE: in_ready=1 (only after reset deasserts). On in_valid&in_ready, register layer_words, eligible = layer_opaque & mask, and backdrop. Initialise top = second = backdrop word {2'b11, 3'd5, backdrop}, with the backdrop flag set on both. Go to SCAN.
  - SCAN: one candidate per cycle in order OBJ(4), 0, 1, 2, 3, using a 3-bit index. in_ready=0.
  - DONE: out_valid=1; top_word and second_word held stable. On out_ready, go to IDLE. in_ready=0.
- Candidate C beats incumbent I iff C is eligible and (I is backdrop OR C.prio < I.prio). An equal priority never replaces, so scan order resolves ties: OBJ beats BG at equal prio, and lower BG index beats higher.
- Per scan cycle:
  - If C beats top: second <= top, top <= C.
  - Else if C beats second: second <= C.
  - Otherwise no change. A non-eligible candidate is a no-op but still consumes its cycle.
- The last scan cycle transitions to DONE.
- Latency: accept edge is cycle 0; scan occupies cycles 1–5; out_valid is high from cycle 6. Throughput is 7 cycles/pixel when out_ready is held high.
- Backpressure: DONE holds indefinitely while out_ready=0, and in_ready stays 0.
- A new set is accepted only in IDLE; there is no overlap with DONE.
- in_valid while in_ready=0 is ignored; the source must hold in_valid until the handshake.
- layer_id in output words is passed through from the input words; the backdrop is layer_id 5.
- All eligible masked out: top = second = backdrop word.
- Exactly one eligible candidate: top = that word, second = backdrop word.
- Inputs (layer_words, masks, backdrop) are sampled only at the accept edge; later changes have no effect.

Decomposition:
- Package pe_pkg holds:
  - typedef pe_word_t (packed struct prio/layer_id/color)
  - constants LAYER_OBJ=4, LAYER_BACKDROP=5, BACKDROP_PRIO=2'b11
  - the FSM state enum {IDLE, SCAN, DONE}
  - the scan-order constant array {4, 0, 1, 2, 3}
- One combinational sub-module, pe_candidate_beats, takes (cand, cand_eligible, inc, inc_is_backdrop) and returns beats. It is instantiated twice (vs top and vs second).

Test Plan:
- Reset then idle: after reset release, in_ready=1, out_valid=0, top_word=0, second_word=0.
- Basic resolve: BG0 prio 1 colour 0x001F, BG1 prio 0 colour 0x03E0, others masked, eligible=0b00011. Expect out_valid at cycle 6, top={0,1,0x03E0}, second={1,0,0x001F}.
- Tie-break: OBJ prio 2 colour 0x7C00 and BG2 prio 2 colour 0x1234, both eligible. Expect top=OBJ word, second=BG2 word.
- Transparency/mask: all five opaque but mask=0, backdrop=0x5555. Expect top=second={3,5,0x5555}. Then mask=0b11111 with opaque=0b00100 and BG2 prio 3. Expect top=BG2 word, second=backdrop.
- Backpressure: hold out_ready=0 for 10 cycles. Expect outputs stable, in_ready=0 and no new accept despite in_valid=1. out_ready=1 gives IDLE the next cycle and in_ready=1.
- Reset mid-scan: assert reset at cycle 3 of SCAN. Expect out_valid and words 0 immediately (asynchronous). After release, a fresh set resolves correctly with no residue from the aborted pixel.
